// File: rtl/wb_riscv_timer_multi.sv
// wb_riscv_timer_multi
// Shared 64-bit RISC-V machine timer (mtime) with a programmable prescaler and
// enable, plus NUM_CMP independent 64-bit mtimecmp comparators, each driving a
// registered level IRQ. Register access is through a Wishbone pipelined slave
// with single-cycle ack; a hi-word shadow makes LO-then-HI reads of mtime atomic.
module wb_riscv_timer_multi #(
  parameter logic [63:0] CLK_FREQUENCY_HZ = 64'd100_000_000,
  parameter int          NUM_CMP          = 4,
  parameter int          PRESCALE_W       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [7:0]         wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_stall_o,
  output logic [NUM_CMP-1:0] irq_o
);

  // Word indices (byte offset >> 2) of the fixed registers
  localparam logic [5:0] IDX_MTIME_LO = 6'd0;
  localparam logic [5:0] IDX_MTIME_HI = 6'd1;
  localparam logic [5:0] IDX_FREQ_LO  = 6'd2;
  localparam logic [5:0] IDX_FREQ_HI  = 6'd3;
  localparam logic [5:0] IDX_CTRL     = 6'd4;
  localparam logic [5:0] IDX_STATUS   = 6'd5;

  // Byte-lane merge of a 32-bit write into an existing word
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Word index of MTIMECMP_LO[n]; the HI word sits one index above
  function automatic logic [5:0] cmp_lo_idx(input int n);
    return 6'(8 + 2 * n);
  endfunction

  // State
  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           cmp_q [NUM_CMP];
  logic [63:0]           cmp_d [NUM_CMP];
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]           shadow_q, shadow_d;
  logic                  ack_q;
  logic [31:0]           dat_q;
  logic [NUM_CMP-1:0]    irq_q;

  // Bus decode
  logic        access;
  logic        wr_en;
  logic        rd_en;
  logic [5:0]  word_idx;
  logic        unused_adr;
  logic        tick;
  logic [31:0] ctrl_rd;
  logic [31:0] status;
  logic [31:0] rdata;

  assign access     = wb_cyc_i & wb_stb_i;
  assign wr_en      = access & wb_we_i;
  assign rd_en      = access & ~wb_we_i;
  assign word_idx   = wb_adr_i[7:2];
  assign unused_adr = ^wb_adr_i[1:0];

  // Prescaler terminal count: this cycle advances mtime
  assign tick = en_q && (pcnt_q == presc_q);

  assign ctrl_rd = 32'(en_q) | (32'(presc_q) << 16);

  // Per-comparator mtime >= mtimecmp[n], unsigned 64-bit
  always_comb begin
    status = '0;
    for (int n = 0; n < NUM_CMP; n++) begin
      status[n] = (mtime_q >= cmp_q[n]);
    end
  end

  // Read data mux for the word addressed this cycle
  always_comb begin
    rdata = '0;
    case (word_idx)
      IDX_MTIME_LO: rdata = mtime_q[31:0];
      IDX_MTIME_HI: rdata = shadow_q;
      IDX_FREQ_LO:  rdata = CLK_FREQUENCY_HZ[31:0];
      IDX_FREQ_HI:  rdata = CLK_FREQUENCY_HZ[63:32];
      IDX_CTRL:     rdata = ctrl_rd;
      IDX_STATUS:   rdata = status;
      default: begin
        for (int n = 0; n < NUM_CMP; n++) begin
          if (word_idx == cmp_lo_idx(n))              rdata = cmp_q[n][31:0];
          else if (word_idx == cmp_lo_idx(n) + 6'd1)  rdata = cmp_q[n][63:32];
        end
      end
    endcase
  end

  // Control register and prescale counter next state; a CTRL write restarts the prescaler
  always_comb begin
    en_d    = en_q;
    presc_d = presc_q;
    if (en_q) pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
    else      pcnt_d = pcnt_q;
    if (wr_en && word_idx == IDX_CTRL) begin
      if (wb_sel_i[0]) en_d = wb_dat_i[0];
      for (int i = 0; i < PRESCALE_W; i++) begin
        if (wb_sel_i[2 + i / 8]) presc_d[i] = wb_dat_i[16 + i];
      end
      pcnt_d = '0;
    end
  end

  // mtime next state: a bus write to either half beats the increment, no carry
  always_comb begin
    mtime_d = mtime_q;
    if (wr_en && word_idx == IDX_MTIME_LO)
      mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wb_dat_i, wb_sel_i)};
    else if (wr_en && word_idx == IDX_MTIME_HI)
      mtime_d = {merge_bytes(mtime_q[63:32], wb_dat_i, wb_sel_i), mtime_q[31:0]};
    else if (tick)
      mtime_d = mtime_q + 64'd1;
  end

  // Comparator next state from byte-selected bus writes
  always_comb begin
    for (int n = 0; n < NUM_CMP; n++) begin
      cmp_d[n] = cmp_q[n];
      if (wr_en && word_idx == cmp_lo_idx(n))
        cmp_d[n][31:0] = merge_bytes(cmp_q[n][31:0], wb_dat_i, wb_sel_i);
      else if (wr_en && word_idx == cmp_lo_idx(n) + 6'd1)
        cmp_d[n][63:32] = merge_bytes(cmp_q[n][63:32], wb_dat_i, wb_sel_i);
    end
  end

  // Reading MTIME_LO freezes the matching hi word for the following HI read
  always_comb begin
    shadow_d = shadow_q;
    if (rd_en && word_idx == IDX_MTIME_LO) shadow_d = mtime_q[63:32];
  end

  // Timer, comparator and control state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q  <= '0;
      en_q     <= 1'b1;
      presc_q  <= '0;
      pcnt_q   <= '0;
      shadow_q <= '0;
      for (int n = 0; n < NUM_CMP; n++) cmp_q[n] <= '1;
    end else begin
      mtime_q  <= mtime_d;
      en_q     <= en_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      shadow_q <= shadow_d;
      for (int n = 0; n < NUM_CMP; n++) cmp_q[n] <= cmp_d[n];
    end
  end

  // Bus response: ack and data one cycle after every accepted access
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= access;
      dat_q <= rd_en ? rdata : 32'd0;
    end
  end

  // Registered level IRQs from the current mtime/mtimecmp values
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_q <= '0;
    else       irq_q <= status[NUM_CMP-1:0];
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign wb_stall_o = 1'b0;
  assign irq_o      = irq_q;

endmodule
